// File: rtl/dlx_mem_responder.sv
// dlx_mem_responder: word-addressed memory slave for the DLX datapath with
// programmable wait states, ACK/ERR handshake and request-level hold protocol.
module dlx_mem_responder #(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 10
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] AO,
  input  logic [31:0] DO,
  input  logic        MR,
  input  logic        MW,
  output logic [31:0] DI,
  output logic        ACK,
  output logic        ERR,
  output logic        BUSY
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;
  localparam logic [3:0] LAST = 4'(WAIT_STATES - 1);
  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         data_q, data_d;
  logic                wr_q, wr_d;
  logic                errl_q, errl_d;
  logic [31:0]         di_q, di_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                req, idle, go_ack, we;
  logic [31:0]         mem [2**ADDR_W];
  logic                unused_ao;
  assign unused_ao = &{1'b0, AO[31:24], AO[1:0]};
  // In IDLE the live inputs feed the datapath so a zero-wait request can
  // complete on the same edge that latches it; afterwards the latches rule.
  always_comb begin
    req    = MR | MW;
    idle   = state_q == S_IDLE;
    idx_d  = idle ? AO[ADDR_W+1:2] : idx_q;
    data_d = idle ? DO : data_q;
    wr_d   = idle ? (MW & ~MR) : wr_q;
    errl_d = idle ? ((|AO[23:ADDR_W+2]) | (MR & MW)) : errl_q;
    cnt_d  = state_q == S_WAIT ? cnt_q + 4'd1 : 4'd0;
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req) state_d = WAIT_STATES == 0 ? S_ACK : S_WAIT;
      S_WAIT: state_d = !req ? S_IDLE : (cnt_q == LAST ? S_ACK : S_WAIT);
      S_ACK:  state_d = S_HOLD;
      S_HOLD: if (!req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    go_ack = state_d == S_ACK && state_q != S_ACK;
    we     = RESET & go_ack & wr_d & ~errl_d;
    di_d   = go_ack ? (errl_d ? 32'd0 : (wr_d ? di_q : mem[idx_d])) : di_q;
    ack_d  = go_ack;
    err_d  = go_ack & errl_d;
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      errl_q  <= 1'b0;
      di_q    <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      errl_q  <= errl_d;
      di_q    <= di_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (we) mem[idx_d] <= data_d;
  end
  assign DI   = di_q;
  assign ACK  = ack_q;
  assign ERR  = err_q;
  assign BUSY = state_q != S_IDLE;
endmodule

// File: tb/tb_dlx_mem_responder.sv
// tb_dlx_mem_responder: directed checks of the DLX memory responder with
// two wait-state settings (2 and 0) sharing clock and reset.
module tb_dlx_mem_responder;
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] ao_a, do_a, di_a, ao_b, do_b, di_b;
  logic mr_a, mw_a, ack_a, err_a, busy_a;
  logic mr_b, mw_b, ack_b, err_b, busy_b;
  int n_chk = 0;
  int n_fail = 0;
  int n;
  logic [31:0] di_s;
  logic err_s;

  always #5 clk = ~clk;

  dlx_mem_responder #(.WAIT_STATES(2), .ADDR_W(10)) u_a (
    .CLK(clk), .RESET(rst_n), .AO(ao_a), .DO(do_a), .MR(mr_a), .MW(mw_a),
    .DI(di_a), .ACK(ack_a), .ERR(err_a), .BUSY(busy_a));

  dlx_mem_responder #(.WAIT_STATES(0), .ADDR_W(10)) u_b (
    .CLK(clk), .RESET(rst_n), .AO(ao_b), .DO(do_b), .MR(mr_b), .MW(mw_b),
    .DI(di_b), .ACK(ack_b), .ERR(err_b), .BUSY(busy_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit b, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!(b ? ack_b : ack_a) && cnt < 20);
  endtask

  // Issue one request, wait for ACK, sample ERR/DI there, then drop and settle.
  task automatic xact(input bit b, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, output int cnt, output logic e, output logic [31:0] q);
    if (b) begin mr_b = r; mw_b = w; ao_b = a; do_b = d; end
    else   begin mr_a = r; mw_a = w; ao_a = a; do_a = d; end
    wait_ack(b, cnt);
    e = b ? err_b : err_a;
    q = b ? di_b : di_a;
    mr_a = 0; mw_a = 0; mr_b = 0; mw_b = 0;
    tick();
    tick();
  endtask

  initial begin
    mr_a = 0; mw_a = 0; ao_a = 0; do_a = 0;
    mr_b = 0; mw_b = 0; ao_b = 0; do_b = 0;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_di", di_a, 32'd0);
    chk("rst_ack", {31'd0, ack_a}, 32'd0);
    chk("rst_err", {31'd0, err_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    rst_n = 1'b1;
    mw_a = 1; ao_a = 32'h10; do_a = 32'hDEADBEEF;
    tick();
    chk("wr_busy_wait", {31'd0, busy_a}, 32'd1);
    chk("wr_noack_early", {31'd0, ack_a}, 32'd0);
    ao_a = 32'h0; do_a = 32'hFFFFFFFF;
    wait_ack(0, n);
    chk("wr_latency", n + 1, 3);
    chk("wr_err", {31'd0, err_a}, 32'd0);
    mw_a = 0;
    tick();
    chk("hold_ack_low", {31'd0, ack_a}, 32'd0);
    chk("hold_busy", {31'd0, busy_a}, 32'd1);
    tick();
    chk("idle_busy", {31'd0, busy_a}, 32'd0);
    xact(0, 1, 0, 32'h10, 32'h0, n, err_s, di_s);
    chk("rd10_lat", n, 3);
    chk("rd10_err", {31'd0, err_s}, 32'd0);
    chk("rd10_di", di_s, 32'hDEADBEEF);
    xact(0, 0, 1, 32'h0, 32'h12345678, n, err_s, di_s);
    chk("wr0_lat", n, 3);
    chk("wr0_err", {31'd0, err_s}, 32'd0);
    xact(0, 0, 1, 32'h1000, 32'h1, n, err_s, di_s);
    chk("oor_lat", n, 3);
    chk("oor_err", {31'd0, err_s}, 32'd1);
    chk("oor_di", di_s, 32'd0);
    xact(0, 1, 0, 32'h0, 32'h0, n, err_s, di_s);
    chk("rd0_after_oor", di_s, 32'h12345678);
    chk("rd0_err", {31'd0, err_s}, 32'd0);
    xact(0, 1, 1, 32'h10, 32'h55, n, err_s, di_s);
    chk("both_err", {31'd0, err_s}, 32'd1);
    chk("both_di", di_s, 32'd0);
    xact(0, 1, 0, 32'h10, 32'h0, n, err_s, di_s);
    chk("rd10_after_both", di_s, 32'hDEADBEEF);
    mw_a = 1; ao_a = 32'h10; do_a = 32'hBAD;
    tick();
    chk("abort_busy_wait", {31'd0, busy_a}, 32'd1);
    mw_a = 0;
    tick();
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_ack", {31'd0, ack_a}, 32'd0);
    chk("abort_di", di_a, 32'hDEADBEEF);
    tick();
    chk("abort_ack2", {31'd0, ack_a}, 32'd0);
    xact(0, 1, 0, 32'h10, 32'h0, n, err_s, di_s);
    chk("rd10_after_abort", di_s, 32'hDEADBEEF);
    mr_a = 1; ao_a = 32'h0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_ack", {31'd0, ack_a}, 32'd0);
    chk("mrst_di", di_a, 32'd0);
    chk("mrst_busy", {31'd0, busy_a}, 32'd0);
    tick();
    tick();
    chk("mrst_ack_hold", {31'd0, ack_a}, 32'd0);
    chk("mrst_busy_hold", {31'd0, busy_a}, 32'd0);
    rst_n = 1'b1;
    xact(0, 1, 0, 32'h0, 32'h0, n, err_s, di_s);
    chk("post_rst_lat", n, 3);
    chk("post_rst_mem", di_s, 32'h12345678);
    mr_a = 1; ao_a = 32'h10;
    wait_ack(0, n);
    chk("held_lat", n, 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("held_no_ack", {31'd0, ack_a}, 32'd0);
      chk("held_busy", {31'd0, busy_a}, 32'd1);
    end
    mr_a = 0;
    tick();
    chk("held_drop_idle", {31'd0, busy_a}, 32'd0);
    mr_a = 1;
    wait_ack(0, n);
    chk("held_reissue_lat", n, 3);
    chk("held_reissue_di", di_a, 32'hDEADBEEF);
    mr_a = 0;
    tick();
    tick();
    mw_b = 1; ao_b = 32'h4; do_b = 32'hCAFEF00D;
    wait_ack(1, n);
    chk("ws0_lat", n, 1);
    chk("ws0_busy_ack", {31'd0, busy_b}, 32'd1);
    mw_b = 0;
    tick();
    chk("ws0_busy_hold", {31'd0, busy_b}, 32'd1);
    chk("ws0_ack_hold", {31'd0, ack_b}, 32'd0);
    tick();
    chk("ws0_busy_idle", {31'd0, busy_b}, 32'd0);
    xact(1, 1, 0, 32'h4, 32'h0, n, err_s, di_s);
    chk("ws0_rd_lat", n, 1);
    chk("ws0_rd_di", di_s, 32'hCAFEF00D);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dlx_mem_responder.md
DLX_MEM_RESPONDER -- requirements
Module: dlx_mem_responder

Interface
REQ-001: Parameter WAIT_STATES, default 2, number of wait cycles inserted before ACK (legal range 0..15).
REQ-002: Parameter ADDR_W, default 10, log2 of memory depth in 32-bit words.
REQ-003: CLK  input  1  single clock; all state changes on its rising edge.
REQ-004: RESET  input  1  asynchronous, active-low reset; 0 resets, 1 runs.
REQ-005: AO  input  32  byte address from the DLX datapath; bits [1:0] are ignored (word access only).
REQ-006: DO  input  32  write data from the DLX datapath MDR.
REQ-007: MR  input  1  memory read request; level held by the initiator until ACK is seen.
REQ-008: MW  input  1  memory write request; level held by the initiator until ACK is seen.
REQ-009: DI  output  32  registered read data to the datapath; valid in the ACK cycle.
REQ-010: ACK  output  1  one-cycle completion pulse.
REQ-011: ERR  output  1  one-cycle error flag; asserted only together with ACK.
REQ-012: BUSY  output  1  high in every state except IDLE.

Function
REQ-013: The block SHALL hold internal storage of 2^ADDR_W 32-bit words, indexed by AO[ADDR_W+1:2].
REQ-014: The FSM SHALL have four states, IDLE, WAIT, ACK and HOLD, with the following transitions:
- IDLE -> WAIT when (MR|MW)=1 and WAIT_STATES>0.
- IDLE -> ACK when (MR|MW)=1 and WAIT_STATES=0.
- WAIT -> ACK when the wait counter reaches WAIT_STATES-1.
- ACK -> HOLD unconditionally.
- HOLD -> IDLE when MR=0 and MW=0; otherwise HOLD is kept.
REQ-015: The responder SHALL latch AO, DO and the request type on the IDLE exit edge and ignore later changes until it returns to IDLE.
REQ-016: The wait counter SHALL be 4 bits, clear to 0 on entry to WAIT, and increment once per WAIT cycle.
REQ-017: Request-to-ACK latency SHALL be WAIT_STATES+1 cycles, counted from the first cycle the request is sampled high in IDLE.
REQ-018: Read: DI SHALL be loaded with mem[latched index] on the edge entering ACK and SHALL hold that value until the next read ACK.
REQ-019: Write: mem[latched index] SHALL be written with the latched DO on the edge entering ACK, never earlier.
REQ-020: Out of range: if any of the latched AO[23:ADDR_W+2] bits is 1, the block SHALL assert ERR with ACK, SHALL NOT write, and SHALL load DI with 0.
REQ-021: AO[31:24] SHALL be ignored; the initiator drives them as 0.
REQ-022: MR and MW both high when sampled in IDLE SHALL complete as an error: ERR=1 with ACK, no write, DI=0.
REQ-023: Abort: if MR and MW both drop while in WAIT, the FSM SHALL return to IDLE on the next edge with no ACK, no write and DI unchanged.
REQ-024: Back-to-back: a request still held in HOLD SHALL NOT start a new transaction; at least one cycle with both requests low is required.
REQ-025: BUSY SHALL be combinational from the state; ACK and ERR SHALL be registered, driven from the state and the latched error.

Reset
REQ-026: While RESET=0 the block SHALL force state=IDLE, counter=0, DI=0, ACK=0, ERR=0 and BUSY=0, independent of CLK.
REQ-027: Memory contents SHALL NOT be cleared by reset; they are undefined until written.
REQ-028: Reset asserted mid-transaction SHALL abandon the transaction: no write, no ACK.
REQ-029: After RESET rises, the first request SHALL be accepted on the first rising CLK edge.

Verification
REQ-030: Write then read, WAIT_STATES=2: MW=1, AO=0x10, DO=0xDEADBEEF, hold -> ACK on the 3rd edge, ERR=0; then MR=1, AO=0x10 -> ACK after 3 cycles with DI=0xDEADBEEF.
REQ-031: WAIT_STATES=0: MR=1 -> ACK on the 1st edge; BUSY is high for exactly 2 cycles (ACK, HOLD) when the request drops with ACK.
REQ-032: Out of range, ADDR_W=10: MW=1, AO=0x00001000, DO=0x1 -> ACK=1 with ERR=1; a subsequent read of AO=0x0 returns the prior contents, unchanged.
REQ-033: Both MR and MW high: MR=MW=1 -> ACK=1, ERR=1, DI=0x00000000, no memory word modified.
REQ-034: Abort and reset: MW=1 dropped after 1 WAIT cycle -> no ACK and the target word is unchanged; RESET=0 pulsed during WAIT of a read -> ACK stays 0, DI=0, BUSY=0 immediately.
REQ-035: Held request: MR kept high for 5 cycles after ACK -> exactly one ACK; the next ACK occurs only after MR drops for one cycle and then rises again.
